// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU.
// One op in flight; the captured result returns on a valid/ready channel tagged with the requester id.
module alu_rr_arbiter #(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      FUN_W   = 4,
  parameter int unsigned      ALU_LAT = 1,
  parameter logic [FUN_W-1:0] NOP_FUN = {FUN_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [FUN_W-1:0] req0_fun_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [FUN_W-1:0] req1_fun_i,
  output logic             req1_ready_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [FUN_W-1:0] alu_fun_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic [3:0]       alu_flags_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [3:0]       rsp_flags_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W  = $clog2(ALU_LAT + 1);
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                gnt0_c, gnt1_c;

  // Arbitration, operand issue, latency count and response hand-back
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset gating keeps READY low while the async reset is held
        if (rst_n) begin
          gnt0_c = req0_valid_i & (~req1_valid_i | ~prio_q);
          gnt1_c = req1_valid_i & (~req0_valid_i |  prio_q);
        end
        if (gnt0_c) begin
          alu_a_d   = req0_a_i;
          alu_b_d   = req0_b_i;
          alu_fun_d = req0_fun_i;
          rsp_id_d  = 1'b0;
          cnt_d     = CNT_W'(ALU_LAT);
          state_d   = WAIT;
        end else if (gnt1_c) begin
          alu_a_d   = req1_a_i;
          alu_b_d   = req1_b_i;
          alu_fun_d = req1_fun_i;
          rsp_id_d  = 1'b1;
          cnt_d     = CNT_W'(ALU_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d  = alu_out_i;
          rsp_flags_d = alu_flags_i;
          alu_fun_d   = NOP_FUN;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          prio_d  = ~rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= NOP_FUN;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign req0_ready_o = gnt0_c;
  assign req1_ready_o = gnt1_c;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_fun_o    = alu_fun_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: two instances (ALU latency 1 and 3), each with a behavioural ALU,
// directed scenarios followed by random traffic checked against a transaction-level model.
module tb_alu_rr_arbiter;

  localparam logic [3:0] NOP = 4'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Index [k] selects the instance (0: latency 1, 1: latency 3), [r] the requester
  logic        req_v [2][2];
  logic [15:0] req_a [2][2];
  logic [15:0] req_b [2][2];
  logic [3:0]  req_f [2][2];
  logic        rdy   [2][2];
  logic [15:0] alu_a [2];
  logic [15:0] alu_b [2];
  logic [3:0]  alu_fun [2];
  logic [15:0] alu_out [2];
  logic [3:0]  alu_flags [2];
  logic        rsp_v [2];
  logic        rsp_r [2];
  logic        rsp_id [2];
  logic [15:0] rsp_data [2];
  logic [3:0]  rsp_flags [2];
  logic        busy [2];

  // Behavioural ALU: {result, Arith, Logic, CMP, Shift}
  function automatic logic [19:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    r  = '0;
    fl = '0;
    case (f)
      4'd0:  begin r = a + b;              fl = 4'b1000; end
      4'd1:  begin r = a - b;              fl = 4'b1000; end
      4'd2:  begin r = a * b;              fl = 4'b1000; end
      4'd3:  begin r = a + 16'd1;          fl = 4'b1000; end
      4'd4:  begin r = a & b;              fl = 4'b0100; end
      4'd5:  begin r = a | b;              fl = 4'b0100; end
      4'd6:  begin r = a ^ b;              fl = 4'b0100; end
      4'd7:  begin r = ~a;                 fl = 4'b0100; end
      4'd8:  begin r = {15'd0, a == b};    fl = 4'b0010; end
      4'd9:  begin r = {15'd0, a > b};     fl = 4'b0010; end
      4'd10: begin r = (a > b) ? a : b;    fl = 4'b0010; end
      4'd11: begin r = (a < b) ? a : b;    fl = 4'b0010; end
      4'd12: begin r = a << b[3:0];        fl = 4'b0001; end
      4'd13: begin r = a >> b[3:0];        fl = 4'b0001; end
      4'd14: begin r = a << 1;             fl = 4'b0001; end
      default: begin r = '0;               fl = 4'b0000; end
    endcase
    return {r, fl};
  endfunction

  logic [19:0] pipe [2][3] = '{default: 20'h0};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= alu_calc(alu_a[k], alu_b[k], alu_fun[k]);
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end
  assign {alu_out[0], alu_flags[0]} = pipe[0][0];
  assign {alu_out[1], alu_flags[1]} = pipe[1][2];

  alu_rr_arbiter #(.WIDTH(16), .FUN_W(4), .ALU_LAT(1), .NOP_FUN(4'hF)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_v[0][0]), .req0_a_i(req_a[0][0]), .req0_b_i(req_b[0][0]),
    .req0_fun_i(req_f[0][0]), .req0_ready_o(rdy[0][0]),
    .req1_valid_i(req_v[0][1]), .req1_a_i(req_a[0][1]), .req1_b_i(req_b[0][1]),
    .req1_fun_i(req_f[0][1]), .req1_ready_o(rdy[0][1]),
    .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_fun_o(alu_fun[0]),
    .alu_out_i(alu_out[0]), .alu_flags_i(alu_flags[0]),
    .rsp_valid_o(rsp_v[0]), .rsp_ready_i(rsp_r[0]), .rsp_id_o(rsp_id[0]),
    .rsp_data_o(rsp_data[0]), .rsp_flags_o(rsp_flags[0]), .busy_o(busy[0])
  );

  alu_rr_arbiter #(.WIDTH(16), .FUN_W(4), .ALU_LAT(3), .NOP_FUN(4'hF)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_v[1][0]), .req0_a_i(req_a[1][0]), .req0_b_i(req_b[1][0]),
    .req0_fun_i(req_f[1][0]), .req0_ready_o(rdy[1][0]),
    .req1_valid_i(req_v[1][1]), .req1_a_i(req_a[1][1]), .req1_b_i(req_b[1][1]),
    .req1_fun_i(req_f[1][1]), .req1_ready_o(rdy[1][1]),
    .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_fun_o(alu_fun[1]),
    .alu_out_i(alu_out[1]), .alu_flags_i(alu_flags[1]),
    .rsp_valid_o(rsp_v[1]), .rsp_ready_i(rsp_r[1]), .rsp_id_o(rsp_id[1]),
    .rsp_data_o(rsp_data[1]), .rsp_flags_o(rsp_flags[1]), .busy_o(busy[1])
  );

  // Transaction-level reference: an owned op plus edges left until its response shows
  bit          m_has  [2];
  int          m_left [2];
  bit          m_prio [2];
  logic [15:0] m_a    [2];
  logic [15:0] m_b    [2];
  logic [3:0]  m_fun  [2];
  bit          m_id   [2];
  logic [15:0] m_rd   [2];
  logic [3:0]  m_rf   [2];
  bit          acc    [2][2];
  bit          obs_rdy [2][2];
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit exp_gnt(input int k, input int r);
    return rst_n && !m_has[k] && req_v[k][r] &&
           (!req_v[k][1-r] || int'(m_prio[k]) == r);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_has[k] = 1'b0; m_left[k] = 0; m_prio[k] = 1'b0;
      m_a[k] = '0; m_b[k] = '0; m_fun[k] = NOP; m_id[k] = 1'b0;
      m_rd[k] = '0; m_rf[k] = '0;
      acc[k][0] = 1'b0; acc[k][1] = 1'b0;
    end
  endtask

  task automatic check_inst(input int k);
    chk("req0_ready", k, 32'(rdy[k][0]), 32'(exp_gnt(k, 0)));
    chk("req1_ready", k, 32'(rdy[k][1]), 32'(exp_gnt(k, 1)));
    chk("rsp_valid",  k, 32'(rsp_v[k]),  32'(m_has[k] && m_left[k] == 0));
    chk("busy",       k, 32'(busy[k]),   32'(m_has[k]));
    chk("alu_fun",    k, 32'(alu_fun[k]), 32'((m_has[k] && m_left[k] > 0) ? m_fun[k] : NOP));
    chk("alu_a",      k, 32'(alu_a[k]),  32'(m_a[k]));
    chk("alu_b",      k, 32'(alu_b[k]),  32'(m_b[k]));
    chk("rsp_id",     k, 32'(rsp_id[k]), 32'(m_id[k]));
    chk("rsp_data",   k, 32'(rsp_data[k]),  32'(m_rd[k]));
    chk("rsp_flags",  k, 32'(rsp_flags[k]), 32'(m_rf[k]));
    obs_rdy[k][0] = rdy[k][0];
    obs_rdy[k][1] = rdy[k][1];
  endtask

  task automatic model_edge(input int k);
    int r;
    acc[k][0] = 1'b0;
    acc[k][1] = 1'b0;
    if (m_has[k]) begin
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) {m_rd[k], m_rf[k]} = alu_calc(m_a[k], m_b[k], m_fun[k]);
      end else if (rsp_r[k]) begin
        m_has[k]  = 1'b0;
        m_prio[k] = !m_id[k];
      end
    end else if (exp_gnt(k, 0) || exp_gnt(k, 1)) begin
      r = exp_gnt(k, 1) ? 1 : 0;
      m_has[k]  = 1'b1;
      m_left[k] = lat_of(k) + 1;
      m_a[k]    = req_a[k][r];
      m_b[k]    = req_b[k][r];
      m_fun[k]  = req_f[k][r];
      m_id[k]   = r[0];
      acc[k][r] = 1'b1;
    end
  endtask

  // One clock: check settled outputs, advance the model at the edge, return at the falling edge
  task automatic step();
    #1;
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input int r, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f);
    req_v[k][r] = v; req_a[k][r] = a; req_b[k][r] = b; req_f[k][r] = f;
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (acc[k][r] || !req_v[k][r]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(k, r, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
          else
            req_v[k][r] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[k][r] = 1'b0;
        end
        acc[k][r] = 1'b0;
      end
      rsp_r[k] = ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    int n;
    int gq[$];
    logic [20:0] rq[$];
    logic [20:0] exp_rsp;

    model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) set_req(k, r, 1'b0, 16'd0, 16'd0, 4'd0);
      rsp_r[k] = 1'b1;
    end

    // Reset held with a requester already valid
    #2 rst_n = 1'b0;
    model_reset();
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0000);
    @(negedge clk);
    repeat (3) step();
    chk("rst_ready0", 0, 32'(rdy[0][0]), 32'd0);
    chk("rst_rsp_valid", 0, 32'(rsp_v[0]), 32'd0);
    chk("rst_alu_fun", 0, 32'(alu_fun[0]), 32'hF);
    rst_n = 1'b1;
    #1 chk("release_ready0", 0, 32'(rdy[0][0]), 32'd1);

    // Single add
    step();
    req_v[0][0] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rsp_v[0] && n < 10);
    chk("lat1_edges", 0, 32'(n), 32'd2);
    chk("add_data", 0, 32'(rsp_data[0]), 32'd12);
    chk("add_flags", 0, 32'(rsp_flags[0]), 32'b1000);
    chk("add_id", 0, 32'(rsp_id[0]), 32'd0);
    step();
    chk("busy_after_accept", 0, 32'(busy[0]), 32'd0);

    // Fresh priority, then continuous contention
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0001);
    set_req(0, 1, 1'b1, 16'd10, 16'd2, 4'b0010);
    for (int c = 0; c < 60 && rq.size() < 4; c++) begin
      step();
      if (obs_rdy[0][0]) gq.push_back(0);
      else if (obs_rdy[0][1]) gq.push_back(1);
      if (rsp_v[0]) rq.push_back({rsp_id[0], rsp_data[0], rsp_flags[0]});
    end
    req_v[0][0] = 1'b0;
    req_v[0][1] = 1'b0;
    chk("grant_count", 0, 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_rsp = (i % 2 == 0) ? {1'b0, 16'd8, 4'b1000} : {1'b1, 16'd20, 4'b1000};
      chk("grant_order", i, (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(i % 2));
      chk("rsp_order", i, (i < rq.size()) ? 32'(rq[i]) : 32'hFFFF_FFFF, 32'(exp_rsp));
    end
    step();

    // Backpressure in RESP with both requesters pushing
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0100);
    rsp_r[0] = 1'b0;
    n = 0;
    do begin
      step(); n++;
      if (acc[0][0]) req_v[0][0] = 1'b0;
    end while (!rsp_v[0] && n < 10);
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0000);
    set_req(0, 1, 1'b1, 16'd10, 16'd2, 4'b0101);
    repeat (5) begin
      step();
      chk("bp_valid", 0, 32'(rsp_v[0]), 32'd1);
      chk("bp_id", 0, 32'(rsp_id[0]), 32'd0);
      chk("bp_data", 0, 32'(rsp_data[0]), 32'd2);
      chk("bp_flags", 0, 32'(rsp_flags[0]), 32'b0100);
      chk("bp_ready0", 0, 32'(rdy[0][0]), 32'd0);
      chk("bp_ready1", 0, 32'(rdy[0][1]), 32'd0);
      chk("bp_busy", 0, 32'(busy[0]), 32'd1);
    end
    rsp_r[0] = 1'b1;
    step();
    chk("bp_idle", 0, 32'(busy[0]), 32'd0);
    req_v[0][0] = 1'b0;
    req_v[0][1] = 1'b0;
    repeat (3) begin
      step();
      chk("bp_no_dup", 0, 32'(rsp_v[0]), 32'd0);
    end

    // Reset while the op waits on the ALU
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0000);
    step();
    req_v[0][0] = 1'b0;
    step();
    chk("mid_busy", 0, 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      chk("mid_no_rsp", 0, 32'(rsp_v[0]), 32'd0);
    end
    set_req(0, 0, 1'b1, 16'd10, 16'd2, 4'b0000);
    set_req(0, 1, 1'b1, 16'd10, 16'd2, 4'b1011);
    #1;
    chk("prio_reset_r0", 0, 32'(rdy[0][0]), 32'd1);
    chk("prio_reset_r1", 0, 32'(rdy[0][1]), 32'd0);
    req_v[0][0] = 1'b0;
    step();
    req_v[0][1] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rsp_v[0] && n < 10);
    chk("min_data", 0, 32'(rsp_data[0]), 32'd2);
    chk("min_flags", 0, 32'(rsp_flags[0]), 32'b0010);
    chk("min_id", 0, 32'(rsp_id[0]), 32'd1);
    step();

    // Three-edge ALU
    set_req(1, 1, 1'b1, 16'd10, 16'd2, 4'b1110);
    step();
    req_v[1][1] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rsp_v[1] && n < 12);
    chk("lat3_edges", 1, 32'(n), 32'd4);
    chk("lat3_data", 1, 32'(rsp_data[1]), 32'h0014);
    chk("lat3_flags", 1, 32'(rsp_flags[1]), 32'b0001);
    chk("lat3_id", 1, 32'(rsp_id[1]), 32'd1);
    step();

    // Random traffic on both instances with one reset pulse
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (c == 2003) rst_n = 1'b1;
      drive_random();
      step();
    end

    for (int k = 0; k < 2; k++) begin
      req_v[k][0] = 1'b0;
      req_v[k][1] = 1'b0;
      rsp_r[k] = 1'b1;
    end
    repeat (10) step();
    chk("drain_busy", 0, 32'(busy[0]), 32'd0);
    chk("drain_busy", 1, 32'(busy[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one registered 16-bit unsigned ALU between two requesters.
- The ALU takes A, B and a 4-bit function code. It returns ALU_OUT and four flags: Arith, Logic, CMP, Shift.
- Per request, the block arbitrates round-robin, issues the operands to the ALU and waits the ALU latency. It then captures the result and flags and returns them on a valid/ready response channel tagged with the requester ID.
- Exactly one operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width
FUN_W, 4, ALU function code width
ALU_LAT, 1, clock edges from ALU inputs being registered to ALU_OUT/flags valid (>=1)
NOP_FUN, 4'b1111, function code that zeroes ALU outputs and flags

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
REQ0_VALID  in  1  requester 0 has an operation
REQ0_A  in  WIDTH  requester 0 operand A
REQ0_B  in  WIDTH  requester 0 operand B
REQ0_FUN  in  FUN_W  requester 0 function code
REQ0_READY  out  1  requester 0 granted/accepted this cycle
REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN, REQ1_READY  as requester 0
ALU_A  out  WIDTH  registered operand A to ALU
ALU_B  out  WIDTH  registered operand B to ALU
ALU_FUN  out  FUN_W  registered function code to ALU
ALU_OUT  in  WIDTH  ALU result
ALU_FLAGS  in  4  {Arith, Logic, CMP, Shift} from ALU
RSP_VALID  out  1  response available
RSP_READY  in  1  consumer accepts response
RSP_ID  out  1  requester that issued the op
RSP_DATA  out  WIDTH  captured ALU_OUT
RSP_FLAGS  out  4  captured ALU_FLAGS, same bit order
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RST low, async):
  - state=IDLE, prio=0, wait counter=0.
  - ALU_A=ALU_B=0, ALU_FUN=NOP_FUN.
  - RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_FLAGS=0, BUSY=0.
  - REQx_READY=0 while RST low.
- Reset mid-operation discards the in-flight op. No response is produced after release.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - REQx_READY is combinational: high only for the granted requester.
  - Grant rule: if only one VALID, grant it. If both VALID, grant prio.
  - Handshake when VALID&READY at an edge:
    - ALU_A/ALU_B/ALU_FUN <= that requester's operands.
    - RSP_ID <= requester index; cnt <= ALU_LAT; go to WAIT.
  - With no VALID, stay in IDLE.
- WAIT:
  - REQx_READY=0.
  - At each edge: if cnt!=0, cnt--. If cnt==0, RSP_DATA <= ALU_OUT, RSP_FLAGS <= ALU_FLAGS, ALU_FUN <= NOP_FUN (operands held), go to RESP.
- RESP:
  - RSP_VALID=1, with RSP_ID/DATA/FLAGS held stable until RSP_VALID&RSP_READY.
  - On acceptance: RSP_VALID <= 0, prio <= ~RSP_ID, go to IDLE.
  - REQx_READY=0 throughout RESP, including the acceptance cycle.
- Latency: handshake edge to RSP_VALID high = ALU_LAT+1 edges (2 for ALU_LAT=1).
- Minimum op-to-op spacing is ALU_LAT+3 cycles.
- Requesters keep VALID and operands stable until READY. Deasserting VALID before grant is legal; the arbiter re-evaluates every IDLE cycle.
- Arithmetic is entirely in the ALU. This block never modifies data or flags, and there are no width conversions.
- ALU_FUN outside WAIT is always NOP_FUN. ALU_A/ALU_B retain their last values.

Test Plan:
1. Reset/idle:
   - Hold RST low with REQ0_VALID=1 -> REQ0_READY=0, RSP_VALID=0, ALU_FUN=4'hF.
   - Release RST -> REQ0_READY=1 in the same cycle.
2. Single op (ALU_LAT=1):
   - REQ0 A=10, B=2, FUN=0000, RSP_READY=1 -> RSP_VALID high 2 edges after handshake.
   - RSP_DATA=12, RSP_FLAGS=4'b1000, RSP_ID=0; BUSY returns low the cycle after acceptance.
3. Contention:
   - Both requesters valid continuously: REQ0 FUN=0001, REQ1 FUN=0010, both A=10, B=2.
   - Grants alternate 0,1,0,1 starting with 0.
   - Responses alternate 8 (id0, flags 1000) and 20 (id1, flags 1000).
4. Backpressure:
   - Hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID/ID/DATA/FLAGS stable, both READYs low, BUSY=1.
   - Raise RSP_READY -> accepted, IDLE next cycle, no duplicate response.
5. Reset mid-op:
   - Pulse RST low while in WAIT -> no RSP_VALID after release, prio=0.
   - Subsequent REQ1 FUN=1011 (A=10, B=2) -> RSP_DATA=2, flags 0010.
6. ALU_LAT=3:
   - REQ1 FUN=1110, A=10, B=2 -> RSP_VALID 4 edges after handshake.
   - RSP_DATA=16'h0014, RSP_FLAGS=4'b0001.
